// File: rtl/rr_arbiter_4_if.sv
// rr_arbiter_4_if: request/grant bundle between requesters and the round-robin arbiter
//   en      - permits new grants (driven by master)
//   req     - level-sensitive request lines, bit i = requester i (driven by master)
//   done    - current owner releases its grant (driven by master)
//   grant   - registered one-hot grant, zero when idle (driven by slave)
//   busy    - registered, equals |grant (driven by slave)
//   timeout - one-cycle pulse on a forced release at the hold limit (driven by slave)
interface rr_arbiter_4_if;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;
    modport master (output en, req, done, input grant, busy, timeout);
    modport slave (input en, req, done, output grant, busy, timeout);
endinterface

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with registered one-hot grant and hold limit
//   MAX_HOLD - maximum consecutive grant cycles per ownership (1..255)
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   arb      - slave side of rr_arbiter_4_if (en/req/done in, grant/busy/timeout out)
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input logic           clk,
    input logic           rst_n,
    rr_arbiter_4_if.slave arb
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] win, owner;
    logic       hit, rel;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end
    // Scan from the farthest position back to ptr so the last hit is the first in search order.
    always_comb begin
        win = ptr_q;
        hit = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (arb.req[ptr_q + 2'(k)]) begin
                win = ptr_q + 2'(k);
                hit = 1'b1;
            end
        end
    end
    assign owner = {grant_q[3] | grant_q[2], grant_q[3] | grant_q[1]};
    assign rel   = arb.done || !arb.req[owner] || cnt_q == 8'(MAX_HOLD);
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (arb.en && hit) begin
                state_d = GRANT;
                grant_d = 4'b0001 << win;
                cnt_d   = 8'd1;
            end
        end else if (rel) begin
            state_d   = IDLE;
            grant_d   = '0;
            ptr_d     = owner + 2'd1;
            cnt_d     = '0;
            // Only the hold limit is left once done and a dropped request are ruled out.
            timeout_d = !arb.done && arb.req[owner];
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        busy_d = |grant_d;
    end
    always_comb begin
        arb.grant   = grant_q;
        arb.busy    = busy_q;
        arb.timeout = timeout_q;
    end
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed self-checking bench for rr_arbiter_4 (MAX_HOLD = 8)
module tb_rr_arbiter_4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    rr_arbiter_4_if bus ();
    rr_arbiter_4 #(.MAX_HOLD(8)) dut (.clk(clk), .rst_n(rst_n), .arb(bus.slave));
    always #5 clk = ~clk;
    // Structural invariants, checked every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            assert ($onehot0(bus.grant) && bus.busy === (|bus.grant))
            else begin
                errors++;
                $error("FAIL invariant: grant=%b busy=%b, required one-hot-or-zero grant with busy=|grant", bus.grant, bus.busy);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [3:0] g, input logic t);
        vectors++;
        assert (bus.grant === g && bus.busy === (|g) && bus.timeout === t)
        else begin
            errors++;
            $error("FAIL %s: got grant=%b busy=%b timeout=%b, want grant=%b busy=%b timeout=%b",
                   tag, bus.grant, bus.busy, bus.timeout, g, |g, t);
        end
    endtask
    initial begin
        bus.en = 1'b0;
        bus.req = 4'b0000;
        bus.done = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", 4'b0000, 1'b0);
        rst_n = 1'b1;
        // Lockout: all requesting, en low.
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lockout", 4'b0000, 1'b0);
        end
        // Rotation with done one cycle after each grant.
        bus.en = 1'b1;
        tick(); chk("rot g0", 4'b0001, 1'b0);
        bus.done = 1'b1; tick(); chk("rot r0", 4'b0000, 1'b0);
        bus.done = 1'b0; tick(); chk("rot g1", 4'b0010, 1'b0);
        bus.done = 1'b1; tick(); chk("rot r1", 4'b0000, 1'b0);
        bus.done = 1'b0; tick(); chk("rot g2", 4'b0100, 1'b0);
        bus.done = 1'b1; tick(); chk("rot r2", 4'b0000, 1'b0);
        bus.done = 1'b0; tick(); chk("rot g3", 4'b1000, 1'b0);
        bus.done = 1'b1; tick(); chk("rot r3", 4'b0000, 1'b0);
        bus.done = 1'b0; tick(); chk("rot wrap", 4'b0001, 1'b0);
        // Skip and wrap: owner 1 releases so ptr=2, then req=0011.
        bus.done = 1'b1; tick(); chk("skip rel0", 4'b0000, 1'b0);
        bus.done = 1'b0; bus.req = 4'b0010; tick(); chk("skip g1", 4'b0010, 1'b0);
        bus.done = 1'b1; bus.req = 4'b0011; tick(); chk("skip rel1", 4'b0000, 1'b0);
        bus.done = 1'b0; tick(); chk("skip wrap", 4'b0001, 1'b0);
        // Timeout: owner 0 drops, requester 2 holds for the full limit.
        bus.req = 4'b0100; tick(); chk("drop0", 4'b0000, 1'b0);
        tick(); chk("to c1", 4'b0100, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("to hold", 4'b0100, 1'b0);
        end
        tick(); chk("to pulse", 4'b0000, 1'b1);
        tick(); chk("to regrant", 4'b0100, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("done hold", 4'b0100, 1'b0);
        end
        bus.done = 1'b1; tick(); chk("done at limit", 4'b0000, 1'b0);
        bus.done = 1'b0;
        // Requester drop, no preemption: ptr=3, owner 1 then req=1001.
        bus.req = 4'b0010; tick(); chk("pre g1", 4'b0010, 1'b0);
        bus.req = 4'b1001; tick(); chk("pre drop", 4'b0000, 1'b0);
        tick(); chk("pre g3", 4'b1000, 1'b0);
        // Async reset mid-grant at counter=5.
        bus.req = 4'b0010; tick(); chk("ar drop3", 4'b0000, 1'b0);
        tick(); chk("ar g1", 4'b0010, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("ar hold", 4'b0010, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1 chk("ar async", 4'b0000, 1'b0);
        @(negedge clk);
        chk("ar in reset", 4'b0000, 1'b0);
        rst_n = 1'b1;
        tick(); chk("ar regrant", 4'b0010, 1'b0);
        // en=0 while granted has no effect.
        bus.en = 1'b0; tick(); chk("en0 hold", 4'b0010, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
